// File: rtl/adder_error_monitor.sv
// Error monitor for an approximate adder: recomputes the exact sum of each accepted
// sample and gathers error count, error-distance sum and maximum over one window.
module adder_error_monitor #(
  parameter int WIDTH  = 16,
  parameter int CNT_W  = 32,
  parameter int ACC_W  = 40,
  parameter int WINDOW = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_a,
  input  logic [WIDTH-1:0]  in_b,
  input  logic [WIDTH-1:0]  in_y,
  input  logic              in_cout,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  sample_count,
  output logic [CNT_W-1:0]  err_count,
  output logic [ACC_W-1:0]  err_sum,
  output logic [WIDTH:0]    err_max
);

  // state | meaning
  // IDLE  | stats held, waiting for start
  // RUN   | accepting samples until WINDOW transfers
  // DRAIN | two cycles letting the last sample reach the stats
  // DONE  | one-cycle done pulse
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [CNT_W-1:0] WIN = CNT_W'(WINDOW);

  state_t           state, state_nxt;
  logic [WIDTH:0]   exact, approx, ed, s1_ed;
  logic             s1_vld;
  logic             drain_cnt;
  logic             xfer, last_xfer;
  logic [ACC_W:0]   sum_ext;

  assign exact  = {1'b0, in_a} + {1'b0, in_b};
  assign approx = {in_cout, in_y};
  // Subtract the smaller from the larger so the distance never wraps.
  assign ed     = (exact >= approx) ? (exact - approx) : (approx - exact);

  assign in_ready  = (state == S_RUN) && (sample_count < WIN);
  assign xfer      = in_valid && in_ready;
  assign last_xfer = xfer && (sample_count == WIN - CNT_W'(1));
  assign busy      = (state == S_RUN) || (state == S_DRAIN);
  assign done      = (state == S_DONE);
  assign sum_ext   = {1'b0, err_sum} + (ACC_W+1)'(s1_ed);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last_xfer) state_nxt = S_DRAIN;
      S_DRAIN: if (drain_cnt) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      s1_vld       <= 1'b0;
      s1_ed        <= '0;
      drain_cnt    <= 1'b0;
      sample_count <= '0;
      err_count    <= '0;
      err_sum      <= '0;
      err_max      <= '0;
    end else begin
      state     <= state_nxt;
      s1_vld    <= xfer;
      drain_cnt <= (state == S_DRAIN) ? ~drain_cnt : 1'b0;
      if (xfer) s1_ed <= ed;
      if (state == S_IDLE && start) begin
        sample_count <= '0;
        err_count    <= '0;
        err_sum      <= '0;
        err_max      <= '0;
      end else begin
        if (xfer) sample_count <= sample_count + CNT_W'(1);
        if (s1_vld) begin
          err_count <= err_count + CNT_W'(s1_ed != '0);
          err_sum   <= sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
          if (s1_ed > err_max) err_max <= s1_ed;
        end
      end
    end
  end

endmodule
